bus_arbiter_rr: RTL and testbench

- Merges NUM_CH independent request/response ports onto one downstream memory port. Ports use the core's pulse protocol: request_enable with mode/addr/wdata/wstrb, and response_enable with data.
- Generalises the core's fixed pair of fetch and mem buses to N channels.
- Adds per-channel request buffering, round-robin arbitration and response routing.
- Sits between core/MMU request sources and the memory/bus controller.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 45 ++++
 rtl/bus_arbiter_rr.sv | 139 +++++++++++++
 tb/tb_bus_arbiter_rr.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Index width for n channels, never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational grant picker over the pending vector, searching from last_grant+1 with wrap.
// With ARB_CH0_PRIORITY_EN defined, channel 0 always wins and channels 1..NUM_CH-1 rotate.
module rr_picker
    import arb_pkg::*;
#(
    parameter int unsigned  NUM_CH = 2,
    localparam int unsigned IDX_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [IDX_W-1:0]  grant,
    output logic              any_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        cand      = '0;
`ifdef ARB_CH0_PRIORITY_EN
        if (pending[0]) begin
            any_valid = 1'b1;
        end else begin
            // last_grant stays within 1..NUM_CH-1, so the rotation never lands on channel 0.
            for (int unsigned k = 1; k < NUM_CH; k++) begin
                cand = IDX_W'(((32'(last_grant) + NUM_CH - 2 + k) % (NUM_CH - 1)) + 1);
                if (!any_valid && pending[cand]) begin
                    any_valid = 1'b1;
                    grant     = cand;
                end
            end
        end
`else
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % NUM_CH);
            if (!any_valid && pending[cand]) begin
                any_valid = 1'b1;
                grant     = cand;
            end
        end
`endif
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Merges NUM_CH pulse-protocol request ports onto one downstream memory port, one transaction
// outstanding at a time. Define ARB_CH0_PRIORITY_EN to give channel 0 fixed highest priority.
module bus_arbiter_rr
    import arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            ch_req_enable,
    input  logic [NUM_CH-1:0]            ch_req_mode,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_req_addr,
    input  logic [NUM_CH*DATA_W-1:0]     ch_req_wdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0] ch_req_wstrb,
    output logic [NUM_CH-1:0]            ch_resp_enable,
    output logic [DATA_W-1:0]            ch_resp_data,
    output logic                         out_request_enable,
    output logic                         out_mode,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [DATA_W-1:0]            out_wdata,
    output logic [(DATA_W/8)-1:0]        out_wstrb,
    input  logic                         in_response_enable,
    input  logic [DATA_W-1:0]            in_resp_data,
    output logic [NUM_CH-1:0]            overflow_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = clog2(NUM_CH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] accept, clear, overflow_d;

    logic              slot_mode_q  [NUM_CH];
    logic [ADDR_W-1:0] slot_addr_q  [NUM_CH];
    logic [DATA_W-1:0] slot_wdata_q [NUM_CH];
    logic [STRB_W-1:0] slot_wstrb_q [NUM_CH];

    logic [IDX_W-1:0]  pick;
    logic              pick_valid;
    logic              resp_fire;
    logic              issue;

    rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .grant      (pick),
        .any_valid  (pick_valid)
    );

    assign resp_fire = (state_q == WAIT) && in_response_enable;
    assign issue     = (state_q == IDLE) && pick_valid;
    assign clear     = resp_fire ? ({{(NUM_CH-1){1'b0}}, 1'b1} << grant_q) : '0;

    // A response frees its slot before same-edge requests are judged, so a re-request is accepted.
    assign accept     = ch_req_enable & (~pending_q | clear);
    assign pending_d  = (pending_q & ~clear) | accept;
    assign overflow_d = overflow_err | (ch_req_enable & pending_q & ~clear);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = WAIT;
                    grant_d = pick;
                end
            end
            WAIT: begin
                if (in_response_enable) begin
                    state_d = IDLE;
`ifdef ARB_CH0_PRIORITY_EN
                    if (grant_q != '0) last_grant_d = grant_q;
`else
                    last_grant_d = grant_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q            <= IDLE;
            grant_q            <= '0;
            last_grant_q       <= IDX_W'(NUM_CH - 1);
            pending_q          <= '0;
            overflow_err       <= '0;
            out_request_enable <= 1'b0;
            out_mode           <= 1'b0;
            out_addr           <= '0;
            out_wdata          <= '0;
            out_wstrb          <= '0;
            ch_resp_enable     <= '0;
            ch_resp_data       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot_mode_q[i]  <= 1'b0;
                slot_addr_q[i]  <= '0;
                slot_wdata_q[i] <= '0;
                slot_wstrb_q[i] <= '0;
            end
        end else begin
            state_q            <= state_d;
            grant_q            <= grant_d;
            last_grant_q       <= last_grant_d;
            pending_q          <= pending_d;
            overflow_err       <= overflow_d;
            out_request_enable <= issue;
            ch_resp_enable     <= clear;
            if (issue) begin
                out_mode  <= slot_mode_q[pick];
                out_addr  <= slot_addr_q[pick];
                out_wdata <= slot_wdata_q[pick];
                out_wstrb <= slot_wstrb_q[pick];
            end
            if (resp_fire) begin
                ch_resp_data <= in_resp_data;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i]) begin
                    slot_mode_q[i]  <= ch_req_mode[i];
                    slot_addr_q[i]  <= ch_req_addr[i*ADDR_W +: ADDR_W];
                    slot_wdata_q[i] <= ch_req_wdata[i*DATA_W +: DATA_W];
                    slot_wstrb_q[i] <= ch_req_wstrb[i*STRB_W +: STRB_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bus_arbiter_rr;
    import arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef ARB_CH0_PRIORITY_EN
    localparam bit PRIO = 1'b1;
    localparam int FAIR_EXP [8] = '{0, 1, 0, 2, 3, 1, 2, 3};
    localparam int PRIO_EXP [5] = '{0, 0, 0, 1, 2};
`else
    localparam bit PRIO = 1'b0;
    localparam int FAIR_EXP [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    localparam int PRIO_EXP [5] = '{0, 1, 2, 0, 0};
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic [N-1:0]    ch_req_enable;
    logic [N-1:0]    ch_req_mode;
    logic [N*AW-1:0] ch_req_addr;
    logic [N*DW-1:0] ch_req_wdata;
    logic [N*SW-1:0] ch_req_wstrb;
    logic [N-1:0]    ch_resp_enable;
    logic [DW-1:0]   ch_resp_data;
    logic            out_request_enable;
    logic            out_mode;
    logic [AW-1:0]   out_addr;
    logic [DW-1:0]   out_wdata;
    logic [SW-1:0]   out_wstrb;
    logic            in_response_enable;
    logic [DW-1:0]   in_resp_data;
    logic [N-1:0]    overflow_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NUM_CH (N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .ch_req_enable      (ch_req_enable),
        .ch_req_mode        (ch_req_mode),
        .ch_req_addr        (ch_req_addr),
        .ch_req_wdata       (ch_req_wdata),
        .ch_req_wstrb       (ch_req_wstrb),
        .ch_resp_enable     (ch_resp_enable),
        .ch_resp_data       (ch_resp_data),
        .out_request_enable (out_request_enable),
        .out_mode           (out_mode),
        .out_addr           (out_addr),
        .out_wdata          (out_wdata),
        .out_wstrb          (out_wstrb),
        .in_response_enable (in_response_enable),
        .in_resp_data       (in_resp_data),
        .overflow_err       (overflow_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit            m_pend  [N];
    bit            m_mode  [N];
    logic [AW-1:0] m_addr  [N];
    logic [DW-1:0] m_wdata [N];
    logic [SW-1:0] m_wstrb [N];
    bit            m_busy;
    int            m_owner;
    int            m_last;
    logic          e_req, e_mode;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [SW-1:0] e_wstrb;
    logic [N-1:0]  e_resp, e_ovf;

    function automatic int model_pick();
        if (PRIO) begin
            if (m_pend[0]) return 0;
            for (int k = 1; k < N; k++) begin
                int c = ((m_last - 1 + k) % (N - 1)) + 1;
                if (m_pend[c]) return c;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (m_pend[c]) return c;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_pend[c] = 1'b0;
            m_mode[c] = 1'b0;
            m_addr[c] = '0;
            m_wdata[c] = '0;
            m_wstrb[c] = '0;
        end
        m_busy = 1'b0;
        m_owner = 0;
        m_last = N - 1;
        e_req = 1'b0; e_mode = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        e_rdata = '0; e_resp = '0; e_ovf = '0;
    endtask

    task automatic model_step();
        int win;
        e_req = 1'b0;
        e_resp = '0;
        if (m_busy) begin
            if (in_response_enable) begin
                e_resp = N'(1) << m_owner;
                e_rdata = in_resp_data;
                m_pend[m_owner] = 1'b0;
                if (!PRIO || m_owner != 0) m_last = m_owner;
                m_busy = 1'b0;
            end
        end else begin
            win = model_pick();
            if (win >= 0) begin
                m_busy = 1'b1;
                m_owner = win;
                e_req = 1'b1;
                e_mode = m_mode[win];
                e_addr = m_addr[win];
                e_wdata = m_wdata[win];
                e_wstrb = m_wstrb[win];
            end
        end
        for (int c = 0; c < N; c++) begin
            if (ch_req_enable[c]) begin
                if (m_pend[c]) begin
                    e_ovf = e_ovf | (N'(1) << c);
                end else begin
                    m_pend[c] = 1'b1;
                    m_mode[c] = ch_req_mode[c];
                    m_addr[c] = ch_req_addr[c*AW +: AW];
                    m_wdata[c] = ch_req_wdata[c*DW +: DW];
                    m_wstrb[c] = ch_req_wstrb[c*SW +: SW];
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_out_req", out_request_enable, e_req);
                check("cyc_out_mode", out_mode, e_mode);
                check("cyc_out_addr", out_addr, e_addr);
                check("cyc_out_wdata", out_wdata, e_wdata);
                check("cyc_out_wstrb", out_wstrb, e_wstrb);
                check("cyc_resp_en", ch_resp_enable, e_resp);
                check("cyc_resp_data", ch_resp_data, e_rdata);
                check("cyc_overflow", overflow_err, e_ovf);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        ch_req_enable = '0;
        in_response_enable = 1'b0;
    endtask

    task automatic set_req(input int ch, input logic mode, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
        ch_req_enable = ch_req_enable | (N'(1) << ch);
        ch_req_mode = (ch_req_mode & ~(N'(1) << ch)) | (N'(mode) << ch);
        ch_req_addr[ch*AW +: AW] = addr;
        ch_req_wdata[ch*DW +: DW] = wdata;
        ch_req_wstrb[ch*SW +: SW] = strb;
    endtask

    // Channel is encoded in address bits [6:4] by every directed test.
    task automatic wait_req(output int ch);
        ch = -1;
        for (int i = 0; i < 30; i++) begin
            if (out_request_enable) begin
                ch = int'((out_addr >> 4) & 32'h7);
                break;
            end
            tick();
        end
        check("grant_seen", out_request_enable, 1'b1);
    endtask

    task automatic drive_resp(input int delay, input logic [DW-1:0] data);
        repeat (delay) tick();
        in_response_enable = 1'b1;
        in_resp_data = data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g;
        int cnt [N];
        int n0;
        int extra;
        ch_req_enable = '0;
        ch_req_mode = '0;
        ch_req_addr = '0;
        ch_req_wdata = '0;
        ch_req_wstrb = '0;
        in_response_enable = 1'b0;
        in_resp_data = '0;
        #1 rstn = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_req", out_request_enable, 1'b0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_resp_en", ch_resp_enable, 4'h0);
        check("rst_resp_data", ch_resp_data, 32'h0);
        check("rst_overflow", overflow_err, 4'h0);
        #2 rstn = 1'b1;
        tick();

        // Single read on channel 1.
        set_req(1, MODE_READ, 32'h8000_0010, 32'h0, 4'h0);
        tick();
        wait_req(g);
        check("rd_grant", g, 1);
        check("rd_addr", out_addr, 32'h8000_0010);
        check("rd_mode", out_mode, 1'b0);
        tick();
        check("rd_pulse_len", out_request_enable, 1'b0);
        drive_resp(1, 32'hDEAD_BEEF);
        tick();
        check("rd_resp_en", ch_resp_enable, 4'b0010);
        check("rd_resp_data", ch_resp_data, 32'hDEAD_BEEF);
        tick();
        check("rd_resp_len", ch_resp_enable, 4'b0000);
        check("rd_data_hold", ch_resp_data, 32'hDEAD_BEEF);

        // Write passthrough on channel 0.
        set_req(0, MODE_WRITE, 32'h0000_0100, 32'h1234_5678, 4'b0011);
        tick();
        wait_req(g);
        check("wr_mode", out_mode, 1'b1);
        check("wr_addr", out_addr, 32'h0000_0100);
        check("wr_wdata", out_wdata, 32'h1234_5678);
        check("wr_wstrb", out_wstrb, 4'b0011);
        drive_resp(0, 32'h0000_2222);
        tick();
        check("wr_resp_en", ch_resp_enable, 4'b0001);
        tick();

        // Fairness: all request together, each re-requests once right after its response.
        do_reset();
        for (int c = 0; c < N; c++) begin
            cnt[c] = 0;
            set_req(c, MODE_READ, 32'hA000_0000 + 32'(c * 16), 32'h0, 4'h0);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            wait_req(g);
            check("fair_order", g, FAIR_EXP[k]);
            drive_resp(1, 32'hC0DE_0000 + 32'(k));
            tick();
            if (g >= 0 && g < N) begin
                cnt[g]++;
                if (cnt[g] < 2) set_req(g, MODE_READ, 32'hA000_0000 + 32'(g * 16), 32'h0, 4'h0);
            end
        end
        tick();

        // Re-request on the edge of the channel's own response is accepted.
        set_req(0, MODE_READ, 32'h0000_0400, 32'h0, 4'h0);
        tick();
        wait_req(g);
        check("sim_first_addr", out_addr, 32'h0000_0400);
        drive_resp(1, 32'h0000_3333);
        set_req(0, MODE_READ, 32'h0000_0500, 32'h0, 4'h0);
        tick();
        check("sim_resp_en", ch_resp_enable, 4'b0001);
        check("sim_no_overflow", overflow_err, 4'b0000);
        wait_req(g);
        check("sim_second_addr", out_addr, 32'h0000_0500);
        drive_resp(0, 32'h0000_4444);
        tick();
        tick();

        // Overflow: second request while the first is still pending.
        set_req(0, MODE_READ, 32'h0000_0200, 32'h0, 4'h0);
        tick();
        set_req(0, MODE_READ, 32'h0000_0300, 32'h0, 4'h0);
        tick();
        wait_req(g);
        check("ovf_addr", out_addr, 32'h0000_0200);
        check("ovf_flag", overflow_err, 4'b0001);
        drive_resp(1, 32'h0000_5555);
        tick();
        check("ovf_resp_en", ch_resp_enable, 4'b0001);
        extra = 0;
        repeat (10) begin
            tick();
            if (ch_resp_enable[0] || out_request_enable) extra++;
        end
        check("ovf_single_resp", extra, 0);
        check("ovf_sticky", overflow_err, 4'b0001);

        // Reset in WAIT, then a stray response.
        set_req(2, MODE_WRITE, 32'h0000_0220, 32'hFFFF_0000, 4'hF);
        tick();
        wait_req(g);
        tick();
        #2 rstn = 1'b0;
        #1;
        check("rstw_out_req", out_request_enable, 1'b0);
        check("rstw_out_addr", out_addr, 32'h0);
        check("rstw_out_wdata", out_wdata, 32'h0);
        check("rstw_out_mode", out_mode, 1'b0);
        check("rstw_resp_data", ch_resp_data, 32'h0);
        check("rstw_overflow", overflow_err, 4'h0);
        @(negedge clk);
        #2 rstn = 1'b1;
        tick();
        drive_resp(0, 32'h0000_7777);
        tick();
        extra = 0;
        repeat (4) begin
            if (ch_resp_enable != '0 || out_request_enable) extra++;
            tick();
        end
        check("rstw_stray_ignored", extra, 0);
        check("rstw_resp_data_zero", ch_resp_data, 32'h0);

        // Channel 0 keeps re-requesting while 1 and 2 wait.
        do_reset();
        for (int c = 0; c < 3; c++) set_req(c, MODE_READ, 32'hB000_0000 + 32'(c * 16), 32'h0, 4'h0);
        tick();
        n0 = 0;
        for (int k = 0; k < 5; k++) begin
            wait_req(g);
            check("prio_order", g, PRIO_EXP[k]);
            drive_resp(1, 32'hB0B0_0000 + 32'(k));
            if (g == 0 && n0 < 2) begin
                n0++;
                set_req(0, MODE_READ, 32'hB000_0000, 32'h0, 4'h0);
            end
            tick();
        end
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
